// File: rtl/onehot_enc_pkg.sv
// rtl/onehot_enc_pkg.sv - shared types and helpers for the one-hot serial encoder
package onehot_enc_pkg;

   localparam int MAX_N = 256;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   function automatic logic popcount_is_one(input logic [MAX_N-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
   endfunction

endpackage

// File: rtl/prio_index.sv
// rtl/prio_index.sv - combinational priority index of a request vector
module prio_index
   import onehot_enc_pkg::*;
#(
   parameter int N         = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic [N-1:0]          vec,
   output logic [clog2(N)-1:0]   idx,
   output logic                  any,
   output logic                  one
);

   localparam int W = clog2(N);

   // The last match in scan order wins, so scan away from the preferred end.
   always_comb begin
      idx = '0;
      if (LSB_FIRST != 0) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
         end
      end
   end

   assign any = |vec;
   assign one = popcount_is_one(MAX_N'(vec));

endmodule

// File: rtl/onehot_serial_encoder.sv
// rtl/onehot_serial_encoder.sv - latches a request vector and streams the index of each set bit
module onehot_serial_encoder
   import onehot_enc_pkg::*;
#(
   parameter int N         = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          in_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [clog2(N)-1:0]   out_idx,
   output logic                  out_last,
   output logic                  out_single,
   output logic                  zero_err
);

   localparam int W = clog2(N);

   state_t         r_state;
   state_t         w_state_next;
   logic [N-1:0]   r_pend;
   logic           r_single;
   logic           r_zero_err;

   logic [W-1:0]   w_idx;
   logic           w_any;
   logic           w_one;
   logic           w_fire;
   logic           w_done;
   logic           w_accept;
   logic           w_vec_zero;
   logic [N-1:0]   w_clear_mask;

   prio_index #(
      .N         (N),
      .LSB_FIRST (LSB_FIRST)
   ) u_prio (
      .vec (r_pend),
      .idx (w_idx),
      .any (w_any),
      .one (w_one)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_accept)    w_state_next = w_vec_zero ? IDLE : SCAN;
      else if (w_done) w_state_next = IDLE;
   end

   always_comb begin
      out_valid  = (r_state == SCAN) & w_any;
      out_idx    = out_valid ? w_idx : '0;
      out_last   = out_valid & w_one;
      out_single = out_valid & r_single;
   end

   // Final beat frees the block in the same cycle so vectors stream without a bubble.
   assign w_fire       = out_valid & out_ready;
   assign w_done       = w_fire & out_last;
   assign in_ready     = (r_state == IDLE) | w_done;
   assign w_accept     = in_valid & in_ready;
   assign w_vec_zero   = (in_vec == '0);
   assign w_clear_mask = ~(N'(1) << w_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend     <= '0;
         r_single   <= 1'b0;
         r_zero_err <= 1'b0;
      end else begin
         r_zero_err <= w_accept & w_vec_zero;
         if (w_accept) begin
            r_pend   <= in_vec;
            r_single <= popcount_is_one(MAX_N'(in_vec));
         end else if (w_fire) begin
            r_pend   <= r_pend & w_clear_mask;
         end
      end
   end

   assign zero_err = r_zero_err;

endmodule
